pipe_ctrl: RTL and testbench

Pipeline sequencing block that consumes the stall/flush decisions of the hazard unit and turns them into fetch-PC updates and per-stage valid bits. It owns the fetch PC, the F/D PC/valid register and the E/M/W valid shift chain; `validM`/`validW` feed the forwarding source muxes. It also keeps halt state and three performance counters.

---
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns hazard-unit stall/flush decisions into fetch-PC
// updates, per-stage valid bits, sticky halt state and performance counters.
module pipe_ctrl #(
    parameter int              WORD     = 32,
    parameter int              CNT_W    = 32,
    parameter logic [WORD-1:0] RESET_PC = {WORD{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             flushE,
    input  logic             takenD,
    input  logic [WORD-1:0]  pcTargetD,
    input  logic             haltD,
    output logic [WORD-1:0]  pcF,
    output logic [WORD-1:0]  pcD,
    output logic             validD,
    output logic             validE,
    output logic             validM,
    output logic             validW,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    logic [WORD-1:0]  pc_f_q, pc_f_d;
    logic [WORD-1:0]  pc_d_q, pc_d_d;
    logic             valid_d_q, valid_d_d;
    logic             valid_e_q, valid_e_d;
    logic             valid_m_q, valid_m_d;
    logic             valid_w_q, valid_w_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next-state for fetch PC, F/D register, valid chain, halt and counters
    always_comb begin
        pc_f_d      = pc_f_q;
        pc_d_d      = pc_d_q;
        valid_d_d   = valid_d_q;
        valid_e_d   = valid_e_q;
        valid_m_d   = valid_e_q;
        valid_w_d   = valid_m_q;
        halted_d    = halted_q;
        retired_d   = retired_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // A stalled fetch drops the redirect; decode re-presents it afterwards.
        if (halted_q) begin
            pc_f_d = pc_f_q;
        end else if (stallF) begin
            pc_f_d = pc_f_q;
        end else if (takenD && valid_d_q) begin
            pc_f_d = pcTargetD;
        end else begin
            pc_f_d = pc_f_q + WORD'(4);
        end

        if (stallD) begin
            pc_d_d    = pc_d_q;
            valid_d_d = valid_d_q;
        end else if (flushD || halted_q || stallF) begin
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b0;
        end else begin
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
        end

        // A held decode instruction must not also advance into E.
        if (flushE || stallD) begin
            valid_e_d = 1'b0;
        end else begin
            valid_e_d = valid_d_q;
        end

        if (valid_d_q && haltD && !stallD) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end

        if (valid_w_q) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end

        if (stallF) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (flushD) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q      <= RESET_PC;
            pc_d_q      <= {WORD{1'b0}};
            valid_d_q   <= 1'b0;
            valid_e_q   <= 1'b0;
            valid_m_q   <= 1'b0;
            valid_w_q   <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc_f_q      <= pc_f_d;
            pc_d_q      <= pc_d_d;
            valid_d_q   <= valid_d_d;
            valid_e_q   <= valid_e_d;
            valid_m_q   <= valid_m_d;
            valid_w_q   <= valid_w_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pcF         = pc_f_q;
    assign pcD         = pc_d_q;
    assign validD      = valid_d_q;
    assign validE      = valid_e_q;
    assign validM      = valid_m_q;
    assign validW      = valid_w_q;
    assign halted      = halted_q;
    assign retired     = retired_q;
    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: sequential fetch, load-use stall, redirects,
// halt/drain, async mid-cycle reset, and PC wrap on a second instance.
module tb_pipe_ctrl;

    localparam int WORD  = 32;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, flushE = 1'b0;
    logic takenD = 1'b0, haltD = 1'b0;
    logic [WORD-1:0] pcTargetD = 32'h0;

    logic [WORD-1:0]  pcF, pcD;
    logic             validD, validE, validM, validW, halted;
    logic [CNT_W-1:0] retired, stallCycles, flushCount;

    logic             w_idle = 1'b0;
    logic [WORD-1:0]  w_tgt = 32'h0;
    logic [WORD-1:0]  w_pcF, w_pcD;
    logic             w_vD, w_vE, w_vM, w_vW, w_halted;
    logic [CNT_W-1:0] w_ret, w_stall, w_flush;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl #(.WORD(WORD), .CNT_W(CNT_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .takenD(takenD),
        .pcTargetD(pcTargetD), .haltD(haltD), .pcF(pcF), .pcD(pcD),
        .validD(validD), .validE(validE), .validM(validM), .validW(validW),
        .halted(halted), .retired(retired), .stallCycles(stallCycles),
        .flushCount(flushCount)
    );

    pipe_ctrl #(.WORD(WORD), .CNT_W(CNT_W), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stallF(w_idle), .stallD(w_idle),
        .flushD(w_idle), .flushE(w_idle), .takenD(w_idle),
        .pcTargetD(w_tgt), .haltD(w_idle), .pcF(w_pcF), .pcD(w_pcD),
        .validD(w_vD), .validE(w_vE), .validM(w_vM), .validW(w_vW),
        .halted(w_halted), .retired(w_ret), .stallCycles(w_stall),
        .flushCount(w_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic fe,
                         input logic tk, input logic [WORD-1:0] tgt, input logic hl);
        stallF = sf; stallD = sd; flushD = fd; flushE = fe;
        takenD = tk; pcTargetD = tgt; haltD = hl;
    endtask

    task automatic chk_main(input string tag, input logic [WORD-1:0] epcf,
                            input logic [WORD-1:0] epcd, input logic [3:0] evalid);
        check({tag, ".pcF"}, 64'(pcF), 64'(epcf));
        check({tag, ".pcD"}, 64'(pcD), 64'(epcd));
        check({tag, ".valid"}, 64'({validD, validE, validM, validW}), 64'(evalid));
    endtask

    task automatic chk_reset(input string tag);
        chk_main(tag, 32'h0, 32'h0, 4'b0000);
        check({tag, ".halted"}, 64'(halted), 64'h0);
        check({tag, ".retired"}, 64'(retired), 64'h0);
        check({tag, ".stall"}, 64'(stallCycles), 64'h0);
        check({tag, ".flush"}, 64'(flushCount), 64'h0);
        check({tag, ".wrap_pcF"}, 64'(w_pcF), 64'hFFFF_FFF8);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2 chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        step(); chk_main("e1", 32'd4, 32'd0, 4'b1000);
        check("e1.wrap_pcF", 64'(w_pcF), 64'hFFFF_FFFC);
        step(); chk_main("e2", 32'd8, 32'd4, 4'b1100);
        check("e2.wrap_pcF", 64'(w_pcF), 64'h0);
        step(); chk_main("e3", 32'd12, 32'd8, 4'b1110);

        // load-use stall for one cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(); chk_main("lu", 32'd12, 32'd8, 4'b1011);
        check("lu.stall", 64'(stallCycles), 64'd1);
        check("lu.retired", 64'(retired), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(); chk_main("e5", 32'd16, 32'd12, 4'b1101);
        check("e5.retired", 64'(retired), 64'd1);
        step(); chk_main("e6", 32'd20, 32'h10, 4'b1110);
        check("e6.retired", 64'(retired), 64'd2);

        // taken branch resolved in decode
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
        step(); chk_main("br", 32'h100, 32'd20, 4'b0111);
        check("br.flush", 64'(flushCount), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(); chk_main("br+1", 32'h104, 32'h100, 4'b1011);
        check("br+1.retired", 64'(retired), 64'd3);

        // redirect arriving during a stall is ignored, then re-presented
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        step(); chk_main("sbr", 32'h104, 32'h100, 4'b1001);
        check("sbr.stall", 64'(stallCycles), 64'd2);
        check("sbr.retired", 64'(retired), 64'd4);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
        step(); chk_main("sbr+1", 32'h200, 32'h104, 4'b0100);
        check("sbr+1.flush", 64'(flushCount), 64'd2);
        check("sbr+1.retired", 64'(retired), 64'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(); chk_main("sbr+2", 32'h204, 32'h200, 4'b1010);
        step(); chk_main("sbr+3", 32'h208, 32'h204, 4'b1101);
        check("sbr+3.retired", 64'(retired), 64'd5);
        step(); chk_main("sbr+4", 32'h20C, 32'h208, 4'b1110);
        check("sbr+4.retired", 64'(retired), 64'd6);

        // asynchronous reset in the middle of the low phase
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step(); chk_main("rel1", 32'd4, 32'd0, 4'b1000);

        repeat (8) step();
        chk_main("pre_halt", 32'h24, 32'h20, 4'b1111);
        check("pre_halt.retired", 64'(retired), 64'd5);

        // halt instruction in decode at 0x20
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(); chk_main("halt", 32'h28, 32'h24, 4'b1111);
        check("halt.halted", 64'(halted), 64'd1);
        check("halt.retired", 64'(retired), 64'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(); chk_main("halt+1", 32'h28, 32'h28, 4'b0111);
        check("halt+1.retired", 64'(retired), 64'd7);
        repeat (5) step();
        chk_main("drained", 32'h28, 32'h28, 4'b0000);
        check("drained.halted", 64'(halted), 64'd1);
        check("drained.retired", 64'(retired), 64'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
